cache_line_xfer: RTL and testbench
==================================

Name: cache_line_xfer

Overview:
- Memory-side transfer engine for one cache line: the reader/drainer of a line store and the source of refill data for it.
- On a miss request it writes back the captured dirty line word by word over a 32-bit memory bus, then fetches the new line word by word.
- It then presents the assembled line to the line store with a one-cycle write+replace strobe.
- Sits between the cache controller/line array and the memory bus master port.

Parameters:
- N_WORDS_PER_LINE, 8, 32-bit words per line; power of two, >= 2.
- TAG_SIZE, 20, tag width in bits, taken from address bits [31:32-TAG_SIZE].

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- req_i  in  1  start a miss transfer; sampled only in IDLE.
- addr_i  in  32  miss address; sampled with req_i.
- dirty_i  in  1  victim line dirty flag; sampled with req_i.
- tag_i  in  TAG_SIZE  victim line tag; sampled with req_i.
- line_i  in  N_WORDS_PER_LINE*32  victim line data; sampled with req_i. Word w is bits [32w+31:32w].
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse in COMMIT.
- line_we_o  out  1  one-cycle write strobe to the line store, in COMMIT.
- line_repl_o  out  1  replace flag, equal to line_we_o.
- line_o  out  N_WORDS_PER_LINE*32  refilled line; stable from COMMIT until the next accepted req_i.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  word-aligned byte address; bits [1:0] are always 0.
- mem_wdata_o  out  32  write data.
- mem_gnt_i  in  1  request accepted when mem_req_o && mem_gnt_i.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.

Behaviour:
- Reset: state IDLE; word counter 0; all captured registers and the line buffer 0. All outputs are 0, including line_o.
- Reset asserted mid-transfer aborts the transfer immediately. No line_we_o is issued.
- OFFS = log2(N_WORDS_PER_LINE*4).
- Write-back address: tag_q, then addr_q[31-TAG_SIZE:OFFS], then cnt, then 2'b00.
- Refill address: addr_q[31:OFFS], then cnt, then 2'b00.
- IDLE:
  - On req_i, capture addr_i, dirty_i, tag_i and line_i.
  - Set cnt to the refill start word (see Optional Feature) and the write-back word counter to 0.
  - Go to WB if dirty_i, else go to RF_REQ.
- WB:
  - Drive mem_req_o=1, mem_we_o=1, the write-back address, and mem_wdata_o = captured word[cnt_wb].
  - On mem_gnt_i, increment cnt_wb. When word N-1 is granted, go to RF_REQ.
  - Address and data are held stable until granted.
- RF_REQ:
  - Drive mem_req_o=1, mem_we_o=0, refill address.
  - On mem_gnt_i go to RF_WAIT.
- RF_WAIT:
  - mem_req_o=0; at most one read is outstanding.
  - On mem_rvalid_i, store mem_rdata_i into buffer word cnt and increment the word count.
  - If this was the N-th word received, go to COMMIT; else advance cnt modulo N and go to RF_REQ.
  - mem_rvalid_i in any other state is ignored.
- COMMIT:
  - Assert line_we_o=1, line_repl_o=1 and done_o=1 for exactly one cycle; line_o = buffer.
  - Return to IDLE.
  - A req_i in the COMMIT cycle is ignored.
- Combinational vs registered outputs:
  - mem_* outputs are a combinational decode of state and registers only; there is no input-to-output path.
  - busy_o, done_o and line_we_o are decoded from state.
- Latency, clean line, zero-wait memory (gnt in the request cycle, rvalid the following cycle):
  - req accepted at cycle 0; COMMIT at cycle 2N+1.
  - A dirty line adds N cycles.
- While busy, further req_i and all input-port changes are ignored.

Optional Feature:
- Macro: CACHE_XFER_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Refill starts at word addr_i[OFFS-1:2] and wraps modulo N back to word 0.
  - Each word is placed at its own index in line_o.
  - The first refill request carries the miss word address.
- Undefined:
  - Refill always starts at word 0 and proceeds ascending.
- Write-back order is always ascending from word 0.

Test Plan:
- Clean miss, addr_i=0x0000_1234, zero-wait memory, N=8:
  - 8 reads to 0x1220..0x123C ascending (0x1234 first when the feature is on, wrapping after 0x123C to 0x1220).
  - line_we_o pulse at cycle 17; line_o word k = rdata of address 0x1220+4k.
- Dirty miss, tag_i=0xABCDE, addr_i=0x0000_1240, line_i words 0x100+k:
  - 8 writes to 0xABCDE240..0xABCDE25C with data 0x100..0x107, then 8 reads at 0x1240.., then COMMIT.
- Backpressure: mem_gnt_i low for 3 cycles on each request -> mem_addr_o and mem_wdata_o remain stable, no word is skipped or duplicated, final line is correct.
- Reset in the middle of a write-back, after 3 words -> all outputs 0, no line_we_o, a new req_i afterwards restarts cleanly.
- req_i held high continuously -> exactly one transfer per IDLE entry. The request is not accepted during COMMIT; the next transfer starts on the cycle after COMMIT.
- Stray mem_rvalid_i in WB and in RF_REQ -> ignored, buffer unchanged.

Source files
------------

// File: rtl/cache_line_xfer.sv
// cache_line_xfer: memory-side transfer engine for one cache line.
// Writes back a dirty victim line over a 32-bit memory bus, refills the
// new line word by word, then hands the assembled line to the line store
// with a one-cycle write+replace strobe.
// Optional build macro: CACHE_XFER_CRITICAL_WORD_FIRST_EN (refill starts at
// the missed word and wraps; default build refills from word 0 ascending).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for req_i; captures miss address and victim line
// S_WB      | writing victim word cnt_wb to memory, held until granted
// S_RF_REQ  | issuing read request for refill word cnt
// S_RF_WAIT | single read outstanding, waiting for mem_rvalid_i
// S_COMMIT  | one-cycle write+replace strobe to the line store

module cache_line_xfer #(
    parameter int N_WORDS_PER_LINE = 8,
    parameter int TAG_SIZE         = 20
) (
    input  logic                             clk,
    input  logic                             rstn_i,
    input  logic                             req_i,
    input  logic [31:0]                      addr_i,
    input  logic                             dirty_i,
    input  logic [TAG_SIZE-1:0]              tag_i,
    input  logic [N_WORDS_PER_LINE*32-1:0]   line_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             line_we_o,
    output logic                             line_repl_o,
    output logic [N_WORDS_PER_LINE*32-1:0]   line_o,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [31:0]                      mem_addr_o,
    output logic [31:0]                      mem_wdata_o,
    input  logic                             mem_gnt_i,
    input  logic                             mem_rvalid_i,
    input  logic [31:0]                      mem_rdata_i
);

    localparam int OFFS = $clog2(N_WORDS_PER_LINE * 4);
    localparam int WW   = $clog2(N_WORDS_PER_LINE);
    localparam logic [WW-1:0] LAST_WORD = WW'(N_WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_RF_REQ,
        S_RF_WAIT,
        S_COMMIT
    } state_t;

    state_t                              state;
    logic [31:OFFS]                      addr_q;
    logic [TAG_SIZE-1:0]                 tag_q;
    logic [N_WORDS_PER_LINE-1:0][31:0]   victim_q;
    logic [N_WORDS_PER_LINE-1:0][31:0]   buf_q;
    logic [WW-1:0]                       cnt;
    logic [WW-1:0]                       cnt_wb;
    logic [WW-1:0]                       rcv;
    logic [WW-1:0]                       start_word;
    logic                                unused_addr;

    // Word-offset bits of the miss address only matter for the refill start.
`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
    assign start_word = addr_i[OFFS-1:2];
`else
    assign start_word = '0;
`endif
    assign unused_addr = ^addr_i[OFFS-1:0];

    // Transfer sequencing: capture on request, write back, refill, commit.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            tag_q    <= '0;
            victim_q <= '0;
            buf_q    <= '0;
            cnt      <= '0;
            cnt_wb   <= '0;
            rcv      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        addr_q   <= addr_i[31:OFFS];
                        tag_q    <= tag_i;
                        victim_q <= line_i;
                        cnt      <= start_word;
                        cnt_wb   <= '0;
                        rcv      <= '0;
                        state    <= dirty_i ? S_WB : S_RF_REQ;
                    end
                end
                S_WB: begin
                    if (mem_gnt_i) begin
                        cnt_wb <= cnt_wb + WW'(1);
                        if (cnt_wb == LAST_WORD) begin
                            state <= S_RF_REQ;
                        end
                    end
                end
                S_RF_REQ: begin
                    if (mem_gnt_i) begin
                        state <= S_RF_WAIT;
                    end
                end
                S_RF_WAIT: begin
                    if (mem_rvalid_i) begin
                        buf_q[cnt] <= mem_rdata_i;
                        cnt        <= cnt + WW'(1);
                        rcv        <= rcv + WW'(1);
                        state      <= (rcv == LAST_WORD) ? S_COMMIT : S_RF_REQ;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory bus decode from state and captured registers only.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state)
            S_WB: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q, addr_q[31-TAG_SIZE:OFFS], cnt_wb, 2'b00};
                mem_wdata_o = victim_q[cnt_wb];
            end
            S_RF_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_q, cnt, 2'b00};
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    // Status and line-store strobes are pure state decodes.
    assign busy_o      = (state != S_IDLE);
    assign done_o      = (state == S_COMMIT);
    assign line_we_o   = (state == S_COMMIT);
    assign line_repl_o = (state == S_COMMIT);
    assign line_o      = buf_q;

endmodule

// File: tb/tb_cache_line_xfer.sv
// Bench for cache_line_xfer: memory responder with configurable grant
// delay, a reference model of the expected bus traffic and refilled line,
// and directed plus randomized transfers.

module tb_cache_line_xfer;

    localparam int N  = 8;
    localparam int TS = 20;
    localparam int LW = N * 32;
    localparam int LB = N * 4;
`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic            clk;
    logic            rstn_i;
    logic            req_i;
    logic [31:0]     addr_i;
    logic            dirty_i;
    logic [TS-1:0]   tag_i;
    logic [LW-1:0]   line_i;
    logic            busy_o;
    logic            done_o;
    logic            line_we_o;
    logic            line_repl_o;
    logic [LW-1:0]   line_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [31:0]     mem_addr_o;
    logic [31:0]     mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;

    cache_line_xfer #(.N_WORDS_PER_LINE(N), .TAG_SIZE(TS)) dut (
        .clk          (clk),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .dirty_i      (dirty_i),
        .tag_i        (tag_i),
        .line_i       (line_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .line_we_o    (line_we_o),
        .line_repl_o  (line_repl_o),
        .line_o       (line_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int          gnt_delay = 0;
    bit          stray_en  = 1'b0;
    logic [31:0] salt;

    logic [31:0] log_wa[$];
    logic [31:0] log_wd[$];
    logic [31:0] log_ra[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_ra[$];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    // Memory responder: grants after gnt_delay stalled cycles, returns read
    // data the cycle after the grant, optionally injects stray rvalids.
    initial begin : responder
        int          wait_cnt;
        bit          rd_pending;
        logic [31:0] rd_addr;
        logic [31:0] st_addr;
        logic [31:0] st_wdata;
        logic        st_we;
        wait_cnt     = 0;
        rd_pending   = 1'b0;
        rd_addr      = '0;
        st_addr      = '0;
        st_wdata     = '0;
        st_we        = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (!rstn_i) begin
                wait_cnt   = 0;
                rd_pending = 1'b0;
                mem_gnt_i  = 1'b0;
                continue;
            end
            if (rd_pending) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(rd_addr);
                rd_pending   = 1'b0;
            end else if (stray_en) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'hDEAD_BEEF;
            end
            mem_gnt_i = 1'b0;
            if (mem_req_o) begin
                if (wait_cnt > 0) begin
                    chk("hold_addr", mem_addr_o, st_addr);
                    chk("hold_wdata", mem_wdata_o, st_wdata);
                    chk("hold_we", mem_we_o, st_we);
                end else begin
                    st_addr  = mem_addr_o;
                    st_wdata = mem_wdata_o;
                    st_we    = mem_we_o;
                end
                if (wait_cnt >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    wait_cnt  = 0;
                    if (mem_we_o) begin
                        log_wa.push_back(mem_addr_o);
                        log_wd.push_back(mem_wdata_o);
                    end else begin
                        log_ra.push_back(mem_addr_o);
                        rd_pending = 1'b1;
                        rd_addr    = mem_addr_o;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_line_we"}, line_we_o, 1'b0);
        chk({tag, "_line_repl"}, line_repl_o, 1'b0);
        chk({tag, "_line"}, line_o, '0);
        chk({tag, "_mem_req"}, mem_req_o, 1'b0);
        chk({tag, "_mem_we"}, mem_we_o, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr_o, '0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, '0);
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling
    // edge of the idle cycle that follows COMMIT.
    task automatic run_xfer(input string tag, input logic [31:0] a, input bit d,
                            input logic [TS-1:0] t, input logic [LW-1:0] l,
                            input int dly, input bit hold);
        int unsigned   base;
        int unsigned   wb_base;
        int unsigned   start;
        int            cyc;
        bit            got;
        logic [LW-1:0] exp_line;
        gnt_delay = dly;
        log_wa.delete(); log_wd.delete(); log_ra.delete();
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        base    = a & ~(LB - 1);
        wb_base = ((int'(t) << (32 - TS)) | (a & ((1 << (32 - TS)) - 1))) & ~(LB - 1);
        start   = CWF ? (a % LB) / 4 : 0;
        for (int k = 0; k < N; k++) begin
            if (d) begin
                exp_wa.push_back(wb_base + 4 * k);
                exp_wd.push_back(l[32 * k +: 32]);
            end
            exp_ra.push_back(base + 4 * ((start + k) % N));
            exp_line[32 * k +: 32] = mem_word(base + 4 * k);
        end
        chk({tag, "_idle_before"}, busy_o, 1'b0);
        addr_i  = a;
        dirty_i = d;
        tag_i   = t;
        line_i  = l;
        req_i   = 1'b1;
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (!hold) req_i = 1'b0;
                addr_i  = $urandom;
                dirty_i = 1'($urandom);
                tag_i   = TS'($urandom);
                for (int k = 0; k < N; k++) line_i[32 * k +: 32] = $urandom;
            end
            if (line_we_o) got = 1'b1;
        end
        chk({tag, "_commit_seen"}, got, 1'b1);
        if (dly == 0) chk({tag, "_latency"}, cyc, 2 * N + 1 + (d ? N : 0));
        chk({tag, "_done"}, done_o, 1'b1);
        chk({tag, "_repl"}, line_repl_o, 1'b1);
        chk({tag, "_busy_commit"}, busy_o, 1'b1);
        chk({tag, "_line"}, line_o, exp_line);
        chk({tag, "_n_writes"}, log_wa.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < log_wa.size(); i++) begin
            chk({tag, "_wr_addr"}, log_wa[i], exp_wa[i]);
            chk({tag, "_wr_data"}, log_wd[i], exp_wd[i]);
        end
        chk({tag, "_n_reads"}, log_ra.size(), exp_ra.size());
        for (int i = 0; i < exp_ra.size() && i < log_ra.size(); i++) begin
            chk({tag, "_rd_addr"}, log_ra[i], exp_ra[i]);
        end
        @(negedge clk);
        chk({tag, "_we_one_cycle"}, line_we_o, 1'b0);
        chk({tag, "_done_one_cycle"}, done_o, 1'b0);
        chk({tag, "_idle_after"}, busy_o, 1'b0);
        chk({tag, "_line_stable"}, line_o, exp_line);
    endtask

    initial begin : timeout
        #300000;
        $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [LW-1:0] l;
        int            wcnt;
        salt    = $urandom;
        rstn_i  = 1'b0;
        req_i   = 1'b0;
        addr_i  = '0;
        dirty_i = 1'b0;
        tag_i   = '0;
        line_i  = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn_i = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // clean miss, zero-wait memory
        for (int k = 0; k < N; k++) l[32 * k +: 32] = $urandom;
        run_xfer("clean", 32'h0000_1234, 1'b0, 20'h12345, l, 0, 1'b0);

        // dirty miss with known victim data
        for (int k = 0; k < N; k++) l[32 * k +: 32] = 32'h100 + k;
        run_xfer("dirty", 32'h0000_1240, 1'b1, 20'hABCDE, l, 0, 1'b0);

        // backpressure: grant withheld for 3 cycles on every request
        for (int k = 0; k < N; k++) l[32 * k +: 32] = $urandom;
        run_xfer("bp", $urandom, 1'b1, TS'($urandom), l, 3, 1'b0);

        // reset in the middle of write-back after 3 words
        gnt_delay = 0;
        log_wa.delete(); log_wd.delete(); log_ra.delete();
        addr_i  = 32'h0000_5A60;
        dirty_i = 1'b1;
        tag_i   = 20'h0F0F0;
        req_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        wcnt  = 0;
        while (log_wa.size() < 3 && wcnt < 50) begin
            @(negedge clk);
            #1;
            wcnt++;
        end
        chk("rst_mid_reached", log_wa.size(), 3);
        @(posedge clk);
        #2;
        rstn_i = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_we", line_we_o, 1'b0);
        end
        rstn_i = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_release");
        for (int k = 0; k < N; k++) l[32 * k +: 32] = $urandom;
        run_xfer("after_rst", $urandom, 1'b1, TS'($urandom), l, 0, 1'b0);

        // req held high: next transfer accepted on the cycle after COMMIT
        for (int k = 0; k < N; k++) l[32 * k +: 32] = $urandom;
        run_xfer("hold1", $urandom, 1'b0, TS'($urandom), l, 0, 1'b1);
        for (int k = 0; k < N; k++) l[32 * k +: 32] = $urandom;
        run_xfer("hold2", $urandom, 1'b1, TS'($urandom), l, 0, 1'b1);
        req_i = 1'b0;
        @(negedge clk);

        // stray rvalid in WB and RF_REQ must not disturb the buffer
        stray_en = 1'b1;
        for (int k = 0; k < N; k++) l[32 * k +: 32] = $urandom;
        run_xfer("stray", $urandom, 1'b1, TS'($urandom), l, 2, 1'b0);
        stray_en = 1'b0;

        // randomized transfers
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) l[32 * k +: 32] = $urandom;
            run_xfer("rand", $urandom, 1'($urandom), TS'($urandom), l,
                     int'($urandom_range(0, 3)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
